pe_mac_bank: RTL



---
 rtl/pe_mac_bank_pkg.sv | 23 ++
 rtl/pe_mac_bank_if.sv | 37 +++
 rtl/pe_mac_bank_round_sat.sv | 53 +++++
 rtl/pe_mac_bank.sv | 112 +++++++++++
 4 files changed

// File: rtl/pe_mac_bank_pkg.sv
// rtl/pe_mac_bank_pkg.sv - shared rounding-mode type and width helpers for the MAC processing element
package pe_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_RSVD      = 2'd3
  } rnd_mode_e;

  function automatic int calc_w(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  function automatic int calc_acc_w(input int int_bits, input int frac_bits, input int guard_bits);
    return 2 * calc_w(int_bits, frac_bits) + guard_bits;
  endfunction

  function automatic int calc_sw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pe_mac_bank_if.sv
// rtl/pe_mac_bank_if.sv - operand token and result handshake bundle between array controller and PE
interface pe_mac_bank_if
  import pe_pkg::*;
#(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 9,
  parameter int ACC_DEPTH = 8
);
  localparam int W  = calc_w(INT_BITS, FRAC_BITS);
  localparam int SW = calc_sw(ACC_DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [SW-1:0] in_sel;
  logic          in_clear;
  logic          in_drain;
  logic [1:0]    in_rnd;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;
  logic          out_sat;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_clear, in_drain, in_rnd, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_clear, in_drain, in_rnd, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_sat
  );

endinterface

// File: rtl/pe_mac_bank_round_sat.sv
// rtl/pe_mac_bank_round_sat.sv - combinational shift-by-FRAC_BITS rounding and saturation to W bits
module pe_round_sat
  import pe_pkg::*;
#(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 9,
  parameter int GUARD_BITS = 4,
  localparam int W     = calc_w(INT_BITS, FRAC_BITS),
  localparam int ACC_W = calc_acc_w(INT_BITS, FRAC_BITS, GUARD_BITS)
) (
  input  logic [ACC_W-1:0] acc,
  input  rnd_mode_e        mode,
  output logic [W-1:0]     data,
  output logic             sat
);

  // One extra MSB keeps the +1 rounding increment from wrapping.
  localparam int QW = ACC_W - FRAC_BITS + 1;
  localparam logic [FRAC_BITS-1:0] LOW_MASK = FRAC_BITS'((1 << (FRAC_BITS - 1)) - 1);

  logic [QW-1:0] q_floor;
  logic [QW-1:0] q_round;
  logic          half_bit;
  logic          below_nz;
  logic          round_up;
  logic          sat_hi;
  logic          sat_lo;

  assign q_floor  = {acc[ACC_W-1], acc[ACC_W-1:FRAC_BITS]};
  assign half_bit = acc[FRAC_BITS-1];
  assign below_nz = |(acc[FRAC_BITS-1:0] & LOW_MASK);

  always_comb begin
    round_up = 1'b0;
    case (mode)
      RND_TRUNC:     round_up = 1'b0;
      RND_HALF_EVEN: round_up = half_bit && (below_nz || q_floor[0]);
      default:       round_up = half_bit;
    endcase
  end

  assign q_round = q_floor + {{(QW - 1){1'b0}}, round_up};

  // In range only when every bit above the W-bit sign matches the true sign.
  assign sat_hi = !q_round[QW-1] && (|q_round[QW-2:W-1]);
  assign sat_lo =  q_round[QW-1] && !(&q_round[QW-2:W-1]);
  assign sat    = sat_hi || sat_lo;

  assign data = sat_hi ? {1'b0, {(W - 1){1'b1}}} :
                sat_lo ? {1'b1, {(W - 1){1'b0}}} :
                q_round[W-1:0];

endmodule

// File: rtl/pe_mac_bank.sv
// rtl/pe_mac_bank.sv - three-stage fixed-point MAC with a banked accumulator and rounded, saturated output
module pe_mac_bank
  import pe_pkg::*;
#(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 9,
  parameter int ACC_DEPTH  = 8,
  parameter int GUARD_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  pe_mac_bank_if.slave  bus
);

  localparam int W     = calc_w(INT_BITS, FRAC_BITS);
  localparam int ACC_W = calc_acc_w(INT_BITS, FRAC_BITS, GUARD_BITS);
  localparam int SW    = calc_sw(ACC_DEPTH);

  logic stall;
  logic accept;

  // A held result freezes every stage, including the bank write.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;

  logic signed [2*W-1:0] prod_next;
  assign prod_next = $signed(bus.in_a) * $signed(bus.in_b);

  logic                  s1_valid;
  logic signed [2*W-1:0] s1_prod;
  logic [SW-1:0]         s1_sel;
  logic                  s1_clear;
  logic                  s1_drain;
  rnd_mode_e             s1_rnd;

  logic [ACC_W-1:0]      acc_bank [ACC_DEPTH];
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]      acc_new;

  logic                  s2_valid;
  logic [ACC_W-1:0]      s2_acc;
  logic [SW-1:0]         s2_sel;
  rnd_mode_e             s2_rnd;

  logic [W-1:0]          rs_data;
  logic                  rs_sat;

  assign prod_ext = ACC_W'(s1_prod);
  assign acc_new  = s1_clear ? prod_ext : acc_bank[s1_sel] + prod_ext;

  pe_round_sat #(
    .INT_BITS   (INT_BITS),
    .FRAC_BITS  (FRAC_BITS),
    .GUARD_BITS (GUARD_BITS)
  ) u_round_sat (
    .acc  (s2_acc),
    .mode (s2_rnd),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s1_sel    <= '0;
      s1_clear  <= 1'b0;
      s1_drain  <= 1'b0;
      s1_rnd    <= RND_TRUNC;
      for (int i = 0; i < ACC_DEPTH; i++) begin
        acc_bank[i] <= '0;
      end
      s2_valid      <= 1'b0;
      s2_acc        <= '0;
      s2_sel        <= '0;
      s2_rnd        <= RND_TRUNC;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_sat   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod  <= prod_next;
        s1_sel   <= bus.in_sel;
        s1_clear <= bus.in_clear;
        s1_drain <= bus.in_drain;
        s1_rnd   <= rnd_mode_e'(bus.in_rnd);
      end

      // Only this stage reads or writes the bank, so same-index tokens chain without bubbles.
      if (s1_valid) begin
        acc_bank[s1_sel] <= acc_new;
      end
      s2_valid <= s1_valid && s1_drain;
      if (s1_valid && s1_drain) begin
        s2_acc <= acc_new;
        s2_sel <= s1_sel;
        s2_rnd <= s1_rnd;
      end

      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_data <= rs_data;
        bus.out_sel  <= s2_sel;
        bus.out_sat  <= rs_sat;
      end
    end
  end

endmodule
